// File: rtl/sim_bus_responder_if.sv
// Bus bundle between the CPU initiator (master) and the memory responder (slave).
// Valid/ready rule: a transfer happens on a rising clk edge where valid & ready are both 1.
interface sim_bus_responder_if #(
  parameter int addr_width = 32,
  parameter int data_width = 32
);
  logic                    rd_addr_valid;
  logic                    rd_addr_ready;
  logic [addr_width-1:0]   rd_addr;
  logic                    rd_data_valid;
  logic                    rd_data_ready;
  logic [data_width-1:0]   rd_data;
  logic                    wr_req_valid;
  logic                    wr_req_ready;
  logic [addr_width-1:0]   wr_addr;
  logic [data_width-1:0]   wr_data;
  logic [data_width/8-1:0] wr_strobe;
  logic                    wr_resp_valid;
  logic                    wr_resp_ready;
  // Debug view of the two channel FSMs (0 = IDLE, 1 = WAIT, 2 = RESP)
  logic [1:0]              rd_state;
  logic [1:0]              wr_state;

  modport master (
    output rd_addr_valid, rd_addr, rd_data_ready,
    output wr_req_valid, wr_addr, wr_data, wr_strobe, wr_resp_ready,
    input  rd_addr_ready, rd_data_valid, rd_data,
    input  wr_req_ready, wr_resp_valid, rd_state, wr_state
  );

  modport slave (
    input  rd_addr_valid, rd_addr, rd_data_ready,
    input  wr_req_valid, wr_addr, wr_data, wr_strobe, wr_resp_ready,
    output rd_addr_ready, rd_data_valid, rd_data,
    output wr_req_ready, wr_resp_valid, rd_state, wr_state
  );
endinterface

// File: rtl/sim_bus_responder.sv
// Memory responder for the copperv CPU bus: independent read and write channels,
// each a 3-state FSM with a configurable wait, backed by a word-addressed array.
module sim_bus_responder #(
  parameter int    data_width    = 32,
  parameter int    addr_width    = 32,
  parameter int    mem_depth     = 1024,
  parameter int    read_latency  = 2,
  parameter int    write_latency = 1,
  parameter string init_file     = ""
) (
  input logic               clk,
  input logic               rst,
  sim_bus_responder_if.slave bus
);
  localparam int iw = $clog2(mem_depth);
  localparam int sw = data_width / 8;
  localparam logic [31:0] rl = 32'(read_latency);
  localparam logic [31:0] wl = 32'(write_latency);
  // The image named by init_file is preloaded into mem by the enclosing bench.
  localparam bit unused_init_image = (init_file != "");

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} wr_state_t;

  logic [data_width-1:0] mem [mem_depth];

  rd_state_t       rd_state, rd_next;
  logic [31:0]     rd_cnt;
  logic [iw-1:0]   rd_idx, rd_in_idx, rd_sample_idx;
  logic            rd_load, rd_sample;

  wr_state_t       wr_state, wr_next;
  logic [31:0]     wr_cnt;
  logic [iw-1:0]   wr_idx, wr_in_idx, wr_commit_idx;
  logic [data_width-1:0] wr_dat, wr_commit_dat;
  logic [sw-1:0]   wr_stb, wr_commit_stb;
  logic            wr_load, wr_commit;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.rd_addr[1:0], bus.rd_addr[addr_width-1:iw+2],
                              bus.wr_addr[1:0], bus.wr_addr[addr_width-1:iw+2]};

  assign rd_in_idx   = bus.rd_addr[iw+1:2];
  assign wr_in_idx   = bus.wr_addr[iw+1:2];
  assign bus.rd_state = rd_state;
  assign bus.wr_state = wr_state;

  // Read channel: next state and the memory sample strobe for the edge into R_RESP.
  always_comb begin
    rd_next       = rd_state;
    rd_load       = 1'b0;
    rd_sample     = 1'b0;
    rd_sample_idx = rd_idx;
    case (rd_state)
      R_IDLE: if (bus.rd_addr_valid && bus.rd_addr_ready) begin
        rd_load       = 1'b1;
        rd_sample_idx = rd_in_idx;
        if (rl == 32'd0) begin
          rd_next   = R_RESP;
          rd_sample = 1'b1;
        end else begin
          rd_next = R_WAIT;
        end
      end
      R_WAIT: if (rd_cnt == 32'd1) begin
        rd_next   = R_RESP;
        rd_sample = 1'b1;
      end
      R_RESP: if (bus.rd_data_valid && bus.rd_data_ready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state          <= R_IDLE;
      rd_cnt            <= '0;
      bus.rd_addr_ready <= 1'b0;
      bus.rd_data_valid <= 1'b0;
      bus.rd_data       <= '0;
    end else begin
      rd_state          <= rd_next;
      bus.rd_addr_ready <= (rd_next == R_IDLE);
      bus.rd_data_valid <= (rd_next == R_RESP);
      if (rd_load) begin
        rd_cnt <= rl;
        rd_idx <= rd_in_idx;
      end else if (rd_state == R_WAIT) begin
        rd_cnt <= rd_cnt - 32'd1;
      end
      if (rd_sample) bus.rd_data <= mem[rd_sample_idx];
    end
  end

  // Write channel: commit happens on the edge into W_RESP, from the bus when there is no wait.
  always_comb begin
    wr_next       = wr_state;
    wr_load       = 1'b0;
    wr_commit     = 1'b0;
    wr_commit_idx = wr_idx;
    wr_commit_dat = wr_dat;
    wr_commit_stb = wr_stb;
    case (wr_state)
      W_IDLE: if (bus.wr_req_valid && bus.wr_req_ready) begin
        wr_load       = 1'b1;
        wr_commit_idx = wr_in_idx;
        wr_commit_dat = bus.wr_data;
        wr_commit_stb = bus.wr_strobe;
        if (wl == 32'd0) begin
          wr_next   = W_RESP;
          wr_commit = 1'b1;
        end else begin
          wr_next = W_WAIT;
        end
      end
      W_WAIT: if (wr_cnt == 32'd1) begin
        wr_next   = W_RESP;
        wr_commit = 1'b1;
      end
      W_RESP: if (bus.wr_resp_valid && bus.wr_resp_ready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state          <= W_IDLE;
      wr_cnt            <= '0;
      bus.wr_req_ready  <= 1'b0;
      bus.wr_resp_valid <= 1'b0;
    end else begin
      wr_state          <= wr_next;
      bus.wr_req_ready  <= (wr_next == W_IDLE);
      bus.wr_resp_valid <= (wr_next == W_RESP);
      if (wr_load) begin
        wr_cnt <= wl;
        wr_idx <= wr_in_idx;
        wr_dat <= bus.wr_data;
        wr_stb <= bus.wr_strobe;
      end else if (wr_state == W_WAIT) begin
        wr_cnt <= wr_cnt - 32'd1;
      end
    end
  end

  // Memory is never cleared; a write still waiting when rst arrives is dropped.
  always_ff @(posedge clk) begin
    if (wr_commit && !rst) begin
      for (int b = 0; b < sw; b++) begin
        if (wr_commit_stb[b]) mem[wr_commit_idx][8*b +: 8] <= wr_commit_dat[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_sim_bus_responder.sv
// Directed bench for sim_bus_responder: vector table on a (2,1)-latency instance,
// hand sequences for backpressure, mid-write reset and the zero-latency same-edge hazard.
module tb_sim_bus_responder;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  sim_bus_responder_if #(.addr_width(32), .data_width(32)) bus_a ();
  sim_bus_responder_if #(.addr_width(32), .data_width(32)) bus_b ();

  sim_bus_responder #(.data_width(32), .addr_width(32), .mem_depth(1024),
                      .read_latency(2), .write_latency(1), .init_file(""))
    dut_a (.clk(clk), .rst(rst_a), .bus(bus_a.slave));

  sim_bus_responder #(.data_width(32), .addr_width(32), .mem_depth(1024),
                      .read_latency(0), .write_latency(0), .init_file(""))
    dut_b (.clk(clk), .rst(rst_b), .bus(bus_b.slave));

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strobe;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts just after a negedge; returns just after the negedge following the response handshake.
  task automatic write_a(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strobe, output int lat);
    int n = 0;
    bus_a.wr_req_valid = 1'b1;
    bus_a.wr_addr      = addr;
    bus_a.wr_data      = data;
    bus_a.wr_strobe    = strobe;
    while (!bus_a.wr_req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("wr_req_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus_a.wr_req_valid = 1'b0;
    lat = 1;
    while (!bus_a.wr_resp_valid && lat < 50) begin @(negedge clk); lat++; end
    @(negedge clk);
  endtask

  task automatic read_a(input logic [31:0] addr, output logic [31:0] data, output int lat);
    int n = 0;
    bus_a.rd_addr_valid = 1'b1;
    bus_a.rd_addr       = addr;
    while (!bus_a.rd_addr_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("rd_addr_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus_a.rd_addr_valid = 1'b0;
    lat = 1;
    while (!bus_a.rd_data_valid && lat < 50) begin @(negedge clk); lat++; end
    data = bus_a.rd_data;
    @(negedge clk);
  endtask

  initial begin
    int          lat;
    int          n;
    logic [31:0] rdata;
    logic [31:0] held;

    vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h10,   32'h11223344, 4'hF, 32'h0};
    vecs[3]  = '{1'b1, 32'h10,   32'hAABBCCDD, 4'h5, 32'h0};
    vecs[4]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'h11BB33DD};
    vecs[5]  = '{1'b1, 32'h1003, 32'h00000005, 4'hF, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000, 32'h0,        4'h0, 32'h00000005};
    vecs[7]  = '{1'b0, 32'h1000, 32'h0,        4'h0, 32'h00000005};
    vecs[8]  = '{1'b1, 32'h20,   32'hCAFEF00D, 4'hF, 32'h0};
    vecs[9]  = '{1'b1, 32'h20,   32'h00000000, 4'h0, 32'h0};
    vecs[10] = '{1'b0, 32'h22,   32'h0,        4'h0, 32'hCAFEF00D};
    vecs[11] = '{1'b1, 32'h24,   32'h00000000, 4'hF, 32'h0};
    vecs[12] = '{1'b1, 32'h24,   32'h12345678, 4'hA, 32'h0};
    vecs[13] = '{1'b0, 32'h24,   32'h0,        4'h0, 32'h12005600};
    vecs[14] = '{1'b0, 32'hFFFF0010, 32'h0,    4'h0, 32'h11BB33DD};

    bus_a.rd_addr_valid = 1'b0; bus_a.rd_addr = '0; bus_a.rd_data_ready = 1'b1;
    bus_a.wr_req_valid = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_a.wr_strobe = '0; bus_a.wr_resp_ready = 1'b1;
    bus_b.rd_addr_valid = 1'b0; bus_b.rd_addr = '0; bus_b.rd_data_ready = 1'b1;
    bus_b.wr_req_valid = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
    bus_b.wr_strobe = '0; bus_b.wr_resp_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_rd_addr_ready", 32'(bus_a.rd_addr_ready), 32'd0);
    check("rst_wr_req_ready",  32'(bus_a.wr_req_ready),  32'd0);
    check("rst_rd_data_valid", 32'(bus_a.rd_data_valid), 32'd0);
    check("rst_rd_data",       bus_a.rd_data,            32'd0);
    check("rst_wr_resp_valid", 32'(bus_a.wr_resp_valid), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    check("post_rst_rd_ready", 32'(bus_a.rd_addr_ready), 32'd1);
    check("post_rst_wr_ready", 32'(bus_a.wr_req_ready),  32'd1);

    // Vector table: writes check ack latency, reads go through the expected queue
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].is_wr) begin
        write_a(vecs[i].addr, vecs[i].data, vecs[i].strobe, lat);
        check($sformatf("vec%0d_wr_lat", i), 32'(lat), 32'd2);
      end else begin
        exp_q.push_back(vecs[i].exp);
        read_a(vecs[i].addr, rdata, lat);
        check($sformatf("vec%0d_rd_lat", i), 32'(lat), 32'd3);
        check($sformatf("vec%0d_rd_data", i), rdata, exp_q.pop_front());
      end
    end

    // Backpressure on read data: word 4 holds 0x11BB33DD
    bus_a.rd_data_ready = 1'b0;
    bus_a.rd_addr_valid = 1'b1;
    bus_a.rd_addr       = 32'h10;
    @(posedge clk);
    @(negedge clk);
    bus_a.rd_addr_valid = 1'b0;
    n = 0;
    while (!bus_a.rd_data_valid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("bp_valid_timeout", 32'd0, 32'd1);
    held = bus_a.rd_data;
    check("bp_data", held, 32'h11BB33DD);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_valid_%0d", k), 32'(bus_a.rd_data_valid), 32'd1);
      check($sformatf("bp_data_%0d", k), bus_a.rd_data, 32'h11BB33DD);
      check($sformatf("bp_addr_ready_%0d", k), 32'(bus_a.rd_addr_ready), 32'd0);
    end
    bus_a.rd_data_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(bus_a.rd_data_valid), 32'd0);
    check("bp_release_ready", 32'(bus_a.rd_addr_ready), 32'd1);

    // Reset while a write to word 4 is waiting
    bus_a.wr_req_valid = 1'b1;
    bus_a.wr_addr      = 32'h10;
    bus_a.wr_data      = 32'h99999999;
    bus_a.wr_strobe    = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bus_a.wr_req_valid = 1'b0;
    check("midrst_wr_state_wait", 32'(bus_a.wr_state), 32'd1);
    rst_a = 1'b1;
    @(negedge clk);
    check("midrst_wr_resp_valid", 32'(bus_a.wr_resp_valid), 32'd0);
    check("midrst_rd_data_valid", 32'(bus_a.rd_data_valid), 32'd0);
    check("midrst_wr_req_ready",  32'(bus_a.wr_req_ready),  32'd0);
    rst_a = 1'b0;
    @(negedge clk);
    check("midrst_wr_ready_back", 32'(bus_a.wr_req_ready),  32'd1);
    check("midrst_rd_ready_back", 32'(bus_a.rd_addr_ready), 32'd1);
    read_a(32'h10, rdata, lat);
    check("midrst_word_unchanged", rdata, 32'h11BB33DD);

    // Zero-latency instance: word 0 = 1, then same-edge read and write of word 0
    bus_b.wr_req_valid = 1'b1; bus_b.wr_addr = 32'h0;
    bus_b.wr_data = 32'h1; bus_b.wr_strobe = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bus_b.wr_req_valid = 1'b0;
    check("b_wr0_resp_valid", 32'(bus_b.wr_resp_valid), 32'd1);
    @(negedge clk);
    bus_b.rd_addr_valid = 1'b1; bus_b.rd_addr = 32'h0;
    bus_b.wr_req_valid = 1'b1; bus_b.wr_addr = 32'h0;
    bus_b.wr_data = 32'h2; bus_b.wr_strobe = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bus_b.rd_addr_valid = 1'b0;
    bus_b.wr_req_valid  = 1'b0;
    check("hazard_rd_valid",   32'(bus_b.rd_data_valid), 32'd1);
    check("hazard_rd_data",    bus_b.rd_data,            32'h1);
    check("hazard_resp_valid", 32'(bus_b.wr_resp_valid), 32'd1);
    @(negedge clk);
    bus_b.rd_addr_valid = 1'b1; bus_b.rd_addr = 32'h0;
    @(posedge clk);
    @(negedge clk);
    bus_b.rd_addr_valid = 1'b0;
    check("hazard_later_valid", 32'(bus_b.rd_data_valid), 32'd1);
    check("hazard_later_data",  bus_b.rd_data,            32'h2);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
